// File: rtl/result_checker.sv
// ============================================================================
//  result_checker
//  Counts vector pairs of a check run, tallies mismatches, flags the first one.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module result_checker #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_actual,
    input  logic [WIDTH-1:0] in_expected,
    input  logic             in_last,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [CNT_W-1:0] first_err_idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] vec_count_q, vec_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
    logic             first_err_valid_q, first_err_valid_d;
    logic             pass_q, pass_d;
    logic             done_q, done_d;

    logic             w_accept;
    logic             w_mismatch;

    assign w_accept   = (state_q == S_RUN) && in_valid;
    assign w_mismatch = (in_actual != in_expected);

    always_comb begin
        state_d           = state_q;
        vec_count_d       = vec_count_q;
        err_count_d       = err_count_q;
        first_err_idx_d   = first_err_idx_q;
        first_err_valid_d = first_err_valid_q;
        pass_d            = pass_q;
        done_d            = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d           = S_RUN;
                    vec_count_d       = '0;
                    err_count_d       = '0;
                    first_err_idx_d   = '0;
                    first_err_valid_d = 1'b0;
                    pass_d            = 1'b0;
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    // Index is captured before this vector's increment: zero-based.
                    if (w_mismatch) begin
                        if (!first_err_valid_q) begin
                            first_err_valid_d = 1'b1;
                            first_err_idx_d   = vec_count_q;
                        end
                        if (err_count_q != C_CNT_MAX) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                    end
                    if (vec_count_q != C_CNT_MAX) begin
                        vec_count_d = vec_count_q + 1'b1;
                    end
                    if (in_last) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_count_d == '0);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= S_IDLE;
            vec_count_q       <= '0;
            err_count_q       <= '0;
            first_err_idx_q   <= '0;
            first_err_valid_q <= 1'b0;
            pass_q            <= 1'b0;
            done_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            vec_count_q       <= vec_count_d;
            err_count_q       <= err_count_d;
            first_err_idx_q   <= first_err_idx_d;
            first_err_valid_q <= first_err_valid_d;
            pass_q            <= pass_d;
            done_q            <= done_d;
        end
    end

    assign in_ready        = (state_q == S_RUN);
    assign busy            = (state_q == S_RUN);
    assign done            = done_q;
    assign pass            = pass_q;
    assign vec_count       = vec_count_q;
    assign err_count       = err_count_q;
    assign first_err_valid = first_err_valid_q;
    assign first_err_idx   = first_err_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_result_checker.sv
// ============================================================================
//  tb_result_checker
//  Scoreboard bench: a 16-bit-counter instance and a 3-bit-counter instance.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_result_checker;

    typedef struct {
        logic [15:0] vec;
        logic [15:0] err;
        logic        fev;
        logic [15:0] fidx;
        logic        pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, in_last;
    logic [7:0] in_actual, in_expected;

    logic        in_ready1, busy1, done1, pass1, fev1;
    logic [15:0] vec1, err1, fidx1;
    logic        in_ready2, busy2, done2, pass2, fev2;
    logic [2:0]  vec2, err2, fidx2;

    int n_checks = 0;
    int n_errors = 0;

    exp_t        q1[$];
    exp_t        q2[$];
    logic [15:0] m_vec[2], m_err[2], m_fidx[2];
    logic        m_fev[2];
    logic [15:0] c_max[2];

    always #5 clk = ~clk;

    result_checker #(.WIDTH(8), .CNT_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
        .in_actual(in_actual), .in_expected(in_expected), .in_last(in_last),
        .busy(busy1), .done(done1), .pass(pass1), .vec_count(vec1), .err_count(err1),
        .first_err_valid(fev1), .first_err_idx(fidx1)
    );

    result_checker #(.WIDTH(8), .CNT_W(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
        .in_actual(in_actual), .in_expected(in_expected), .in_last(in_last),
        .busy(busy2), .done(done2), .pass(pass2), .vec_count(vec2), .err_count(err2),
        .first_err_valid(fev2), .first_err_idx(fidx2)
    );

    // Run results are popped and compared whenever either instance pulses done.
    always @(negedge clk) begin
        if (done1) begin
            n_checks++;
            if (q1.size() == 0) begin
                n_errors++;
                $display("FAIL sb16_unexpected_done: got done=1, required no done");
            end else begin
                exp_t e;
                e = q1.pop_front();
                if (vec1 !== e.vec || err1 !== e.err || fev1 !== e.fev ||
                    fidx1 !== e.fidx || pass1 !== e.pass) begin
                    n_errors++;
                    $display("FAIL sb16_result: got vec=%0d err=%0d fev=%0b fidx=%0d pass=%0b, required vec=%0d err=%0d fev=%0b fidx=%0d pass=%0b",
                             vec1, err1, fev1, fidx1, pass1, e.vec, e.err, e.fev, e.fidx, e.pass);
                end
            end
        end
        if (done2) begin
            n_checks++;
            if (q2.size() == 0) begin
                n_errors++;
                $display("FAIL sb3_unexpected_done: got done=1, required no done");
            end else begin
                exp_t e;
                e = q2.pop_front();
                if ({13'd0, vec2} !== e.vec || {13'd0, err2} !== e.err || fev2 !== e.fev ||
                    {13'd0, fidx2} !== e.fidx || pass2 !== e.pass) begin
                    n_errors++;
                    $display("FAIL sb3_result: got vec=%0d err=%0d fev=%0b fidx=%0d pass=%0b, required vec=%0d err=%0d fev=%0b fidx=%0d pass=%0b",
                             vec2, err2, fev2, fidx2, pass2, e.vec, e.err, e.fev, e.fidx, e.pass);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        for (int k = 0; k < 2; k++) begin
            m_vec[k]  = '0;
            m_err[k]  = '0;
            m_fidx[k] = '0;
            m_fev[k]  = 1'b0;
        end
    endtask

    task automatic do_start;
        start = 1'b1;
        step();
        start = 1'b0;
        model_clear();
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] e, input logic l);
        in_actual   = a;
        in_expected = e;
        in_last     = l;
        in_valid    = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (a != e) begin
                if (!m_fev[k]) begin
                    m_fev[k]  = 1'b1;
                    m_fidx[k] = m_vec[k];
                end
                if (m_err[k] != c_max[k]) m_err[k] = m_err[k] + 16'd1;
            end
            if (m_vec[k] != c_max[k]) m_vec[k] = m_vec[k] + 16'd1;
        end
        if (l) begin
            q1.push_back('{vec: m_vec[0], err: m_err[0], fev: m_fev[0], fidx: m_fidx[0], pass: (m_err[0] == 0)});
            q2.push_back('{vec: m_vec[1], err: m_err[1], fev: m_fev[1], fidx: m_fidx[1], pass: (m_err[1] == 0)});
        end
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        n_checks++;
        if (busy1 !== 1'b0 || in_ready1 !== 1'b0 || done1 !== 1'b0 || pass1 !== 1'b0 ||
            vec1 !== 16'd0 || err1 !== 16'd0 || fev1 !== 1'b0 || fidx1 !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_state: got busy=%0b rdy=%0b done=%0b pass=%0b vec=%0d err=%0d fev=%0b fidx=%0d, required all 0",
                     busy1, in_ready1, done1, pass1, vec1, err1, fev1, fidx1);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_idle_ignore;
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_actual = 8'h12;
        in_expected = 8'h34;
        step();
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_checks++;
        if (busy1 !== 1'b0 || in_ready1 !== 1'b0 || vec1 !== 16'd0 || err1 !== 16'd0) begin
            n_errors++;
            $display("FAIL idle_ignore: got busy=%0b rdy=%0b vec=%0d err=%0d, required 0 0 0 0",
                     busy1, in_ready1, vec1, err1);
        end
    endtask

    task automatic test_clean;
        do_start();
        n_checks++;
        if (busy1 !== 1'b1 || in_ready1 !== 1'b1 || vec1 !== 16'd0) begin
            n_errors++;
            $display("FAIL clean_run_state: got busy=%0b rdy=%0b vec=%0d, required 1 1 0", busy1, in_ready1, vec1);
        end
        send(8'h00, 8'h00, 1'b0);
        send(8'h11, 8'h11, 1'b0);
        send(8'h22, 8'h22, 1'b0);
        send(8'h33, 8'h33, 1'b1);
        n_checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || in_ready1 !== 1'b0 || pass1 !== 1'b1 ||
            vec1 !== 16'd4 || err1 !== 16'd0 || fev1 !== 1'b0) begin
            n_errors++;
            $display("FAIL clean_done: got done=%0b busy=%0b rdy=%0b pass=%0b vec=%0d err=%0d fev=%0b, required 1 0 0 1 4 0 0",
                     done1, busy1, in_ready1, pass1, vec1, err1, fev1);
        end
        step();
        n_checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b0 || pass1 !== 1'b1 || vec1 !== 16'd4) begin
            n_errors++;
            $display("FAIL clean_hold: got done=%0b busy=%0b pass=%0b vec=%0d, required 0 0 1 4",
                     done1, busy1, pass1, vec1);
        end
    endtask

    task automatic test_errors;
        logic [7:0] exp_tab [5];
        exp_tab = '{8'hA5, 8'hA4, 8'hA5, 8'hA4, 8'hA5};
        do_start();
        n_checks++;
        if (pass1 !== 1'b0 || vec1 !== 16'd0 || err1 !== 16'd0) begin
            n_errors++;
            $display("FAIL errors_clear: got pass=%0b vec=%0d err=%0d, required 0 0 0", pass1, vec1, err1);
        end
        for (int i = 0; i < 5; i++) begin
            send(8'hA5, exp_tab[i], (i == 4));
            n_checks++;
            if (vec1 !== m_vec[0] || err1 !== m_err[0] || fidx1 !== m_fidx[0] || fev1 !== m_fev[0]) begin
                n_errors++;
                $display("FAIL errors_vec%0d: got vec=%0d err=%0d fidx=%0d fev=%0b, required vec=%0d err=%0d fidx=%0d fev=%0b",
                         i, vec1, err1, fidx1, fev1, m_vec[0], m_err[0], m_fidx[0], m_fev[0]);
            end
        end
        n_checks++;
        if (done1 !== 1'b1 || err1 !== 16'd2 || fidx1 !== 16'd1 || pass1 !== 1'b0 || vec1 !== 16'd5) begin
            n_errors++;
            $display("FAIL errors_done: got done=%0b err=%0d fidx=%0d pass=%0b vec=%0d, required 1 2 1 0 5",
                     done1, err1, fidx1, pass1, vec1);
        end
        step();
    endtask

    task automatic test_backpressure;
        logic pat [6];
        logic [15:0] v_before, e_before;
        int sent;
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        sent = 0;
        do_start();
        for (int i = 0; i < 6; i++) begin
            if (pat[i]) begin
                send(8'h5A, (sent == 1) ? 8'h5B : 8'h5A, (i == 5));
                sent++;
            end else begin
                v_before    = vec1;
                e_before    = err1;
                in_actual   = 8'hFF;
                in_expected = 8'h00;
                step();
                n_checks++;
                if (vec1 !== v_before || err1 !== e_before || busy1 !== 1'b1) begin
                    n_errors++;
                    $display("FAIL bp_gap%0d: got vec=%0d err=%0d busy=%0b, required vec=%0d err=%0d busy=1",
                             i, vec1, err1, busy1, v_before, e_before);
                end
            end
        end
        n_checks++;
        if (done1 !== 1'b1 || vec1 !== 16'd3 || err1 !== 16'd1 || fidx1 !== 16'd1) begin
            n_errors++;
            $display("FAIL bp_done: got done=%0b vec=%0d err=%0d fidx=%0d, required 1 3 1 1",
                     done1, vec1, err1, fidx1);
        end
        step();
    endtask

    task automatic test_start_ignored;
        do_start();
        send(8'h01, 8'h01, 1'b0);
        send(8'h02, 8'h03, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (vec1 !== 16'd2 || err1 !== 16'd1 || fev1 !== 1'b1 || busy1 !== 1'b1) begin
            n_errors++;
            $display("FAIL start_mid_run: got vec=%0d err=%0d fev=%0b busy=%0b, required 2 1 1 1",
                     vec1, err1, fev1, busy1);
        end
        send(8'h04, 8'h04, 1'b0);
        send(8'h05, 8'h05, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (busy1 !== 1'b0 || in_ready1 !== 1'b0 || vec1 !== 16'd4 || err1 !== 16'd1 || pass1 !== 1'b0) begin
            n_errors++;
            $display("FAIL start_in_done: got busy=%0b rdy=%0b vec=%0d err=%0d pass=%0b, required 0 0 4 1 0",
                     busy1, in_ready1, vec1, err1, pass1);
        end
        step();
    endtask

    task automatic test_reset_midrun;
        do_start();
        send(8'h10, 8'h11, 1'b0);
        send(8'h20, 8'h20, 1'b0);
        send(8'h30, 8'h30, 1'b0);
        rst = 1'b1;
        in_valid = 1'b1;
        in_last  = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_clear();
        n_checks++;
        if (busy1 !== 1'b0 || in_ready1 !== 1'b0 || done1 !== 1'b0 || pass1 !== 1'b0 ||
            vec1 !== 16'd0 || err1 !== 16'd0 || fev1 !== 1'b0 || fidx1 !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_midrun: got busy=%0b rdy=%0b done=%0b pass=%0b vec=%0d err=%0d fev=%0b fidx=%0d, required all 0",
                     busy1, in_ready1, done1, pass1, vec1, err1, fev1, fidx1);
        end
        step();
        do_start();
        for (int i = 0; i < 4; i++) send(8'(i * 17), 8'(i * 17), (i == 3));
        n_checks++;
        if (done1 !== 1'b1 || pass1 !== 1'b1 || vec1 !== 16'd4) begin
            n_errors++;
            $display("FAIL reset_rerun: got done=%0b pass=%0b vec=%0d, required 1 1 4", done1, pass1, vec1);
        end
        step();
    endtask

    task automatic test_saturation;
        do_start();
        for (int i = 0; i < 10; i++) begin
            send(8'h01, 8'h00, (i == 9));
            if (i == 7) begin
                n_checks++;
                if (vec2 !== 3'd7 || err2 !== 3'd7) begin
                    n_errors++;
                    $display("FAIL sat_reach: got vec=%0d err=%0d, required 7 7", vec2, err2);
                end
            end
        end
        n_checks++;
        if (done2 !== 1'b1 || vec2 !== 3'd7 || err2 !== 3'd7 || pass2 !== 1'b0 || fidx2 !== 3'd0 || fev2 !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_done: got done=%0b vec=%0d err=%0d pass=%0b fidx=%0d fev=%0b, required 1 7 7 0 0 1",
                     done2, vec2, err2, pass2, fidx2, fev2);
        end
        n_checks++;
        if (vec1 !== 16'd10 || err1 !== 16'd10) begin
            n_errors++;
            $display("FAIL sat_wide: got vec=%0d err=%0d, required 10 10", vec1, err1);
        end
        step();
    endtask

    initial begin
        c_max[0]    = 16'hFFFF;
        c_max[1]    = 16'd7;
        rst         = 1'b1;
        start       = 1'b0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_actual   = '0;
        in_expected = '0;
        model_clear();
        repeat (2) step();

        test_reset();
        test_idle_ignore();
        test_clean();
        test_errors();
        test_backpressure();
        test_start_ignored();
        test_reset_midrun();
        test_saturation();
        repeat (2) step();

        n_checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: got %0d/%0d pending results, required 0/0", q1.size(), q2.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
